// File: rtl/vis_unpacker_pkg.sv
// Shared constants and helpers for the narrow visibility stream receiver.
package vis_unpacker_pkg;

   localparam int BYTE_W      = 8;
   localparam int FRAME_CNT_W = 16;

   // Framing error code shared with the bus bridge and bench-side checker.
   typedef enum logic [1:0] {
      FERR_NONE  = 2'b00,
      FERR_SHORT = 2'b01,
      FERR_LEN   = 2'b10,
      FERR_BOTH  = 2'b11
   } frame_err_e;

   // Bytes per {revis, imvis} word for a given component width.
   function automatic int keeps_of(input int accum);
      return (2 * accum) / BYTE_W;
   endfunction

   // Width of a byte-lane index; never narrower than one bit.
   function automatic int idx_width(input int n);
      if (n <= 2) begin
         return 1;
      end else begin
         return $clog2(n);
      end
   endfunction

   // Combine the two framing checks into one error code.
   function automatic frame_err_e frame_err(input logic short_err, input logic len_err);
      frame_err_e e;
      case ({len_err, short_err})
         2'b00:   e = FERR_NONE;
         2'b01:   e = FERR_SHORT;
         2'b10:   e = FERR_LEN;
         2'b11:   e = FERR_BOTH;
         default: e = FERR_NONE;
      endcase
      return e;
   endfunction

endpackage

// File: rtl/vis_unpacker_outreg.sv
// Single-entry valid/ready output register. A load may replace the held
// entry in the same cycle it drains; the producer never loads while the
// entry is held and not being drained.
module vis_unpacker_outreg #(
   parameter int W = 65
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o
);

   logic         valid_q;
   logic         valid_d;
   logic [W-1:0] data_q;
   logic [W-1:0] data_d;

   // Next state: a load wins, otherwise a completed handshake empties the entry.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // Entry flops with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_q <= 1'b0;
         data_q  <= {W{1'b0}};
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/vis_unpacker.sv
// Receiver for the 8-bit visibility byte stream: reassembles {revis, imvis}
// words, checks frame alignment and length, and presents one word per
// valid/ready handshake.
module vis_unpacker
   import vis_unpacker_pkg::*;
#(
   parameter int ACCUM  = 32,
   parameter int NWORDS = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             s_tvalid,
   output logic             s_tready,
   input  logic             s_tkeep,
   input  logic             s_tlast,
   input  logic [7:0]       s_tdata,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_last,
   output logic [ACCUM-1:0] m_revis,
   output logic [ACCUM-1:0] m_imvis,
   output logic             err_short_o,
   output logic             err_len_o,
   output logic [15:0]      frames_o
);

   localparam int KEEPS = keeps_of(ACCUM);
   localparam int BIW   = idx_width(KEEPS);
   localparam int CBITS = $clog2(NWORDS + 1);
   localparam int WW    = 2 * ACCUM;
   localparam int LW    = BYTE_W * (KEEPS - 1);

   localparam logic [BIW-1:0]   BIDX_LAST = BIW'(KEEPS - 1);
   localparam logic [BIW-1:0]   BIDX_ZERO = {BIW{1'b0}};
   localparam logic [CBITS-1:0] WCNT_MAX  = {CBITS{1'b1}};
   localparam logic [CBITS-1:0] WCNT_EXP  = CBITS'(NWORDS);
   localparam logic [CBITS-1:0] WCNT_ZERO = {CBITS{1'b0}};

   // Byte-lane index, lanes 0..KEEPS-2 of the word in progress, and frame state.
   logic [BIW-1:0]         bidx_q,   bidx_d;
   logic [LW-1:0]          lane_q,   lane_d;
   logic [CBITS-1:0]       wcnt_q,   wcnt_d;
   logic                   over_q,   over_d;
   logic [FRAME_CNT_W-1:0] frames_q, frames_d;
   frame_err_e             ferr_q,   ferr_d;

   logic             accept_s;
   logic             kept_s;
   logic             at_last_s;
   logic             load_s;
   logic [CBITS-1:0] words_s;
   logic             over_s;
   logic             short_s;
   logic             len_s;
   logic [WW:0]      out_data_s;

   // Only the completing byte is held off, and only while the output is full.
   assign s_tready = !((bidx_q == BIDX_LAST) && m_valid && !m_ready);

   // Handshake qualifiers for the current byte.
   always_comb begin
      accept_s  = s_tvalid && s_tready;
      kept_s    = accept_s && s_tkeep;
      at_last_s = (bidx_q == BIDX_LAST);
      load_s    = kept_s && at_last_s;
   end

   // Lane fill, word counting and frame close.
   always_comb begin
      bidx_d   = bidx_q;
      lane_d   = lane_q;
      wcnt_d   = wcnt_q;
      over_d   = over_q;
      frames_d = frames_q;
      ferr_d   = FERR_NONE;
      words_s  = wcnt_q;
      over_s   = over_q;
      short_s  = 1'b0;
      len_s    = 1'b0;

      if (load_s) begin
         bidx_d = BIDX_ZERO;
         // Saturating count; the sticky overflow flag keeps overlong frames
         // visible even when the saturated value happens to equal NWORDS.
         if (wcnt_q == WCNT_MAX) begin
            words_s = wcnt_q;
         end else begin
            words_s = wcnt_q + CBITS'(1);
         end
         if (wcnt_q >= WCNT_EXP) begin
            over_s = 1'b1;
         end else begin
            over_s = over_q;
         end
      end else if (kept_s) begin
         bidx_d = bidx_q + BIW'(1);
         for (int i = 0; i < KEEPS - 1; i++) begin
            if (bidx_q == BIW'(i)) begin
               lane_d[i*BYTE_W +: BYTE_W] = s_tdata;
            end else begin
               lane_d[i*BYTE_W +: BYTE_W] = lane_q[i*BYTE_W +: BYTE_W];
            end
         end
      end else begin
         bidx_d = bidx_q;
      end

      // Any accepted tlast closes the frame, including one on a null byte.
      if (accept_s && s_tlast) begin
         if (s_tkeep) begin
            short_s = !at_last_s;
         end else begin
            short_s = (bidx_q != BIDX_ZERO);
         end
         len_s    = over_s || (words_s != WCNT_EXP);
         ferr_d   = frame_err(short_s, len_s);
         bidx_d   = BIDX_ZERO;
         wcnt_d   = WCNT_ZERO;
         over_d   = 1'b0;
         frames_d = frames_q + 16'd1;
      end else begin
         wcnt_d = words_s;
         over_d = over_s;
      end
   end

   // Receiver state flops with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         bidx_q   <= BIDX_ZERO;
         lane_q   <= {LW{1'b0}};
         wcnt_q   <= WCNT_ZERO;
         over_q   <= 1'b0;
         frames_q <= {FRAME_CNT_W{1'b0}};
         ferr_q   <= FERR_NONE;
      end else begin
         bidx_q   <= bidx_d;
         lane_q   <= lane_d;
         wcnt_q   <= wcnt_d;
         over_q   <= over_d;
         frames_q <= frames_d;
         ferr_q   <= ferr_d;
      end
   end

   // The completing byte goes straight into the output register as the MSB lane.
   assign out_data_s = {s_tlast, s_tdata, lane_q};

   vis_unpacker_outreg #(
      .W (WW + 1)
   ) u_outreg (
      .clock   (clock),
      .reset   (reset),
      .load_i  (load_s),
      .data_i  (out_data_s),
      .ready_i (m_ready),
      .valid_o (m_valid),
      .data_o  ({m_last, m_revis, m_imvis})
   );

   assign err_short_o = ferr_q[0];
   assign err_len_o   = ferr_q[1];
   assign frames_o    = frames_q;

endmodule
